// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU datapath stages.
//   - MEM_NOP / MEM_READ / MEM_WRITE / MEM_RSVD : memory_mode encodings
//   - OP_* : ALU opcode constants used by the upstream decode/ALU stages
//   - DATA_W : default datapath width
//   - mem_wb_state_t : state encoding of the memory/writeback stage
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W = 16;

  // memory_mode encodings
  localparam logic [1:0] MEM_NOP   = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [1:0] MEM_RSVD  = 2'b11;

  // ALU opcodes
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hC;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } mem_wb_state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// -----------------------------------------------------------------------------
// mem_timeout_counter
// Watchdog counter for an outstanding memory access.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear of the count (has priority over enable)
//   enable     : count one cycle of waiting
//   limit      : number of waiting cycles allowed
//   expired    : high during the cycle whose closing edge is the limit-th
//                waiting edge, so the owner can act on that same edge
// -----------------------------------------------------------------------------
module mem_timeout_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // count_reg holds the number of waiting edges already seen, so the edge
  // that closes this cycle is the (count_reg+1)-th one.
  assign expired = enable && (count_reg == (limit - 1'b1));

endmodule

// File: rtl/mem_writeback.sv
// -----------------------------------------------------------------------------
// mem_writeback
// Memory-access / writeback stage after the ALU. Accepts one ALU result per
// transfer, performs an optional data-memory access over a req/ack handshake
// and issues single-cycle register-file and PC write strobes.
//
// Optional feature: define MEM_WB_TIMEOUT_EN to add a watchdog that abandons
// an access after TIMEOUT_CYCLES waiting cycles and sets the sticky err flag.
//
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   in_valid / in_ready             : upstream handshake (ready only in IDLE)
//   alu_out                         : ALU result or memory address
//   write_rD, write_pc              : writeback flags from the ALU
//   memory_mode                     : 00 NOP, 01 READ, 10 WRITE, 11 reserved
//   rd_sel, store_data              : destination register, store data
//   mem_req/mem_we/mem_addr/mem_wdata : memory request (held until ack)
//   mem_rdata, mem_ack              : memory response
//   rf_we/rf_waddr/rf_wdata         : register-file write (1-cycle strobe)
//   pc_we/pc_wdata                  : PC write (1-cycle strobe)
//   busy                            : access outstanding
//   err                             : sticky timeout error
// -----------------------------------------------------------------------------
module mem_writeback #(
  parameter int DATA_W         = cpu_pkg::DATA_W,
  parameter int REG_AW         = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              write_rD,
  input  logic              write_pc,
  input  logic [1:0]        memory_mode,
  input  logic [REG_AW-1:0] rd_sel,
  input  logic [DATA_W-1:0] store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wdata,
  output logic              busy,
  output logic              err
);

  import cpu_pkg::*;

  mem_wb_state_t     state_reg,     state_next;
  logic              mem_req_reg,   mem_req_next;
  logic              mem_we_reg,    mem_we_next;
  logic [DATA_W-1:0] mem_addr_reg,  mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [REG_AW-1:0] rd_reg,        rd_next;
  logic              wr_rd_reg,     wr_rd_next;
  logic              rf_we_reg,     rf_we_next;
  logic [REG_AW-1:0] rf_waddr_reg,  rf_waddr_next;
  logic [DATA_W-1:0] rf_wdata_reg,  rf_wdata_next;
  logic              pc_we_reg,     pc_we_next;
  logic [DATA_W-1:0] pc_wdata_reg,  pc_wdata_next;

  logic is_mem_op;
  assign is_mem_op = (memory_mode == MEM_READ) || (memory_mode == MEM_WRITE);

`ifdef MEM_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic err_reg, err_next;
  logic timeout_expired;

  // Counts only waiting cycles; an ack on the limit cycle is handled first
  // in the next-state logic, so it wins over the timeout.
  mem_timeout_counter #(
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_reg == ST_IDLE),
    .enable  ((state_reg == ST_MEM) && !mem_ack),
    .limit   (CNT_W'(TIMEOUT_CYCLES)),
    .expired (timeout_expired)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rd_reg        <= '0;
      wr_rd_reg     <= 1'b0;
      rf_we_reg     <= 1'b0;
      rf_waddr_reg  <= '0;
      rf_wdata_reg  <= '0;
      pc_we_reg     <= 1'b0;
      pc_wdata_reg  <= '0;
`ifdef MEM_WB_TIMEOUT_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rd_reg        <= rd_next;
      wr_rd_reg     <= wr_rd_next;
      rf_we_reg     <= rf_we_next;
      rf_waddr_reg  <= rf_waddr_next;
      rf_wdata_reg  <= rf_wdata_next;
      pc_we_reg     <= pc_we_next;
      pc_wdata_reg  <= pc_wdata_next;
`ifdef MEM_WB_TIMEOUT_EN
      err_reg       <= err_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rd_next        = rd_reg;
    wr_rd_next     = wr_rd_reg;
    rf_we_next     = 1'b0;             // strobes default low: one-cycle pulses
    rf_waddr_next  = rf_waddr_reg;
    rf_wdata_next  = rf_wdata_reg;
    pc_we_next     = 1'b0;
    pc_wdata_next  = pc_wdata_reg;
`ifdef MEM_WB_TIMEOUT_EN
    err_next       = err_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_mem_op) begin
            // write_pc is deliberately dropped for memory operations
            mem_req_next   = 1'b1;
            mem_we_next    = (memory_mode == MEM_WRITE);
            mem_addr_next  = alu_out;
            mem_wdata_next = store_data;
            rd_next        = rd_sel;
            wr_rd_next     = write_rD;
            state_next     = ST_MEM;
          end else begin
            // NOP and the reserved code both write back the ALU result
            rf_we_next = write_rD;
            if (write_rD) begin
              rf_waddr_next = rd_sel;
              rf_wdata_next = alu_out;
            end
            pc_we_next = write_pc;
            if (write_pc) begin
              pc_wdata_next = alu_out;
            end
          end
        end
      end

      ST_MEM: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          state_next   = ST_IDLE;
          if (!mem_we_reg && wr_rd_reg) begin
            rf_we_next    = 1'b1;
            rf_waddr_next = rd_reg;
            rf_wdata_next = mem_rdata;
          end
        end
`ifdef MEM_WB_TIMEOUT_EN
        else if (timeout_expired) begin
          mem_req_next = 1'b0;
          err_next     = 1'b1;
          state_next   = ST_IDLE;
        end
`endif
      end

      default: begin
        state_next   = ST_IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rf_we     = rf_we_reg;
  assign rf_waddr  = rf_waddr_reg;
  assign rf_wdata  = rf_wdata_reg;
  assign pc_we     = pc_we_reg;
  assign pc_wdata  = pc_wdata_reg;

`ifdef MEM_WB_TIMEOUT_EN
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_writeback.sv
// -----------------------------------------------------------------------------
// tb_mem_writeback
// Self-checking bench for mem_writeback. Expected register-file / PC
// writebacks are queued when a transfer is driven and compared by a monitor
// whenever a write strobe appears. Memory-side signals are checked directly
// cycle by cycle. Define MEM_WB_TIMEOUT_EN to also exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_mem_writeback;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int TMO    = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_out;
  logic              write_rD;
  logic              write_pc;
  logic [1:0]        memory_mode;
  logic [REG_AW-1:0] rd_sel;
  logic [DATA_W-1:0] store_data;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              pc_we;
  logic [DATA_W-1:0] pc_wdata;
  logic              busy;
  logic              err;

  mem_writeback #(
    .DATA_W         (DATA_W),
    .REG_AW         (REG_AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_out     (alu_out),
    .write_rD    (write_rD),
    .write_pc    (write_pc),
    .memory_mode (memory_mode),
    .rd_sel      (rd_sel),
    .store_data  (store_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .pc_we       (pc_we),
    .pc_wdata    (pc_wdata),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              rf;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              pc;
    logic [DATA_W-1:0] pdata;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  int check_count = 0;
  int pass_count  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_exp(input logic rf, input logic [REG_AW-1:0] wa,
                          input logic [DATA_W-1:0] wd, input logic pc,
                          input logic [DATA_W-1:0] pd);
    wb_exp_t e;
    e.rf = rf; e.waddr = wa; e.wdata = wd; e.pc = pc; e.pdata = pd;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [1:0] mode, input logic [DATA_W-1:0] a,
                       input logic [REG_AW-1:0] rd, input logic wrd, input logic wpc,
                       input logic [DATA_W-1:0] sd);
    in_valid = v; memory_mode = mode; alu_out = a; rd_sel = rd;
    write_rD = wrd; write_pc = wpc; store_data = sd;
  endtask

  // Writeback monitor: every strobe cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (rf_we || pc_we) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", {30'd0, rf_we, pc_we}, 32'd0);
      end else begin
        wb_exp_t e;
        e = sb_q.pop_front();
        check("wb_rf_we", 32'(rf_we), 32'(e.rf));
        check("wb_pc_we", 32'(pc_we), 32'(e.pc));
        if (e.rf) begin
          check("wb_rf_waddr", 32'(rf_waddr), 32'(e.waddr));
          check("wb_rf_wdata", 32'(rf_wdata), 32'(e.wdata));
        end
        if (e.pc) check("wb_pc_wdata", 32'(pc_wdata), 32'(e.pdata));
        $display("wb: rf_we=%0b waddr=%0d wdata=%h pc_we=%0b pc_wdata=%h",
                 rf_we, rf_waddr, rf_wdata, pc_we, pc_wdata);
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0);

    // ---------------- reset values
    @(negedge clk);
    check("rst_mem_req",  32'(mem_req), 0);
    check("rst_mem_we",   32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_rf_we",    32'(rf_we), 0);
    check("rst_pc_we",    32'(pc_we), 0);
    check("rst_busy",     32'(busy), 0);
    check("rst_err",      32'(err), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    $display("txn: reset released");

    // ---------------- NOP, register write only
    @(negedge clk);
    drive(1'b1, 2'b00, 16'h1234, 3'd3, 1'b1, 1'b0, 16'h0);
    push_exp(1'b1, 3'd3, 16'h1234, 1'b0, 16'h0);
    $display("txn: NOP rf write 0x1234 -> r3");

    // ---------------- back-to-back: rf+pc, then reserved code with pc only
    @(negedge clk);
    drive(1'b1, 2'b00, 16'h00F0, 3'd6, 1'b1, 1'b1, 16'h0);
    push_exp(1'b1, 3'd6, 16'h00F0, 1'b1, 16'h00F0);
    $display("txn: NOP rf+pc write 0x00F0");
    @(negedge clk);
    drive(1'b1, 2'b11, 16'h0100, 3'd1, 1'b0, 1'b1, 16'h0);
    push_exp(1'b0, 3'd0, 16'h0, 1'b1, 16'h0100);
    $display("txn: reserved-mode pc write 0x0100");
    @(negedge clk);
    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);

    // ---------------- READ with 3-cycle wait; write_pc must be ignored
    drive(1'b1, 2'b01, 16'h0040, 3'd5, 1'b1, 1'b1, 16'h0);
    push_exp(1'b1, 3'd5, 16'hBEEF, 1'b0, 16'h0);
    $display("txn: READ addr 0x0040 -> r5");
    @(negedge clk);
    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("rd_mem_req",  32'(mem_req), 1);
      check("rd_mem_addr", 32'(mem_addr), 32'h0040);
      check("rd_mem_we",   32'(mem_we), 0);
      check("rd_in_ready", 32'(in_ready), 0);
      check("rd_busy",     32'(busy), 1);
      if (i == 2) begin
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
      end
    end
    @(negedge clk);
    check("rd_done_req",   32'(mem_req), 0);
    check("rd_done_ready", 32'(in_ready), 1);
    mem_rdata = 16'hDEAD;   // ack stays high one extra cycle: must be ignored
    @(negedge clk);
    mem_ack = 1'b0;
    check("rd_ack_hold_req", 32'(mem_req), 0);
    @(negedge clk);

    // ---------------- WRITE, next transfer held valid during the wait
    drive(1'b1, 2'b10, 16'h0010, 3'd2, 1'b1, 1'b0, 16'hA5A5);
    $display("txn: WRITE addr 0x0010 data 0xA5A5");
    @(negedge clk);
    drive(1'b1, 2'b00, 16'h5555, 3'd2, 1'b1, 1'b0, 16'h1111);
    push_exp(1'b1, 3'd2, 16'h5555, 1'b0, 16'h0);
    $display("txn: NOP rf write 0x5555 -> r2 (held while busy)");
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      check("wr_mem_req",   32'(mem_req), 1);
      check("wr_mem_we",    32'(mem_we), 1);
      check("wr_mem_addr",  32'(mem_addr), 32'h0010);
      check("wr_mem_wdata", 32'(mem_wdata), 32'hA5A5);
      check("wr_in_ready",  32'(in_ready), 0);
      if (i == 1) mem_ack = 1'b1;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    check("wr_done_req",   32'(mem_req), 0);
    check("wr_done_ready", 32'(in_ready), 1);
    @(negedge clk);   // held NOP accepted at the edge before this point
    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);

    // ---------------- reset during an outstanding READ
    drive(1'b1, 2'b01, 16'h0080, 3'd4, 1'b1, 1'b0, 16'h0);
    $display("txn: READ addr 0x0080 aborted by reset");
    @(negedge clk);
    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    check("ab_mem_req_before", 32'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ab_mem_req",  32'(mem_req), 0);
    check("ab_mem_addr", 32'(mem_addr), 0);
    check("ab_busy",     32'(busy), 0);
    check("ab_in_ready", 32'(in_ready), 1);
    mem_ack = 1'b1;
    mem_rdata = 16'h7777;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mem_ack = 1'b0;
    check("ab_no_req", 32'(mem_req), 0);

`ifdef MEM_WB_TIMEOUT_EN
    // ---------------- watchdog: no ack ever arrives
    @(negedge clk);
    drive(1'b1, 2'b01, 16'h0020, 3'd7, 1'b1, 1'b0, 16'h0);
    $display("txn: READ addr 0x0020 with no ack (timeout)");
    @(negedge clk);
    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      n++;
      @(negedge clk);
    end
    check("tmo_req_cycles", 32'(n), TMO);
    check("tmo_err",        32'(err), 1);
    check("tmo_in_ready",   32'(in_ready), 1);
    drive(1'b1, 2'b00, 16'h0033, 3'd1, 1'b1, 1'b0, 16'h0);
    push_exp(1'b1, 3'd1, 16'h0033, 1'b0, 16'h0);
    $display("txn: NOP rf write 0x0033 -> r1 after timeout");
    @(negedge clk);
    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    check("tmo_err_sticky", 32'(err), 1);
`else
    n = 0;
    check("no_tmo_err", 32'(err), 32'(n));
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  // Global guard so the run always ends on its own.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
